mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access stage of the 5-stage RISC-V pipeline, directly downstream of EX. Holds the EX/MEM and MEM/WB pipeline registers. Drives a request/ready data-memory port with byte/half/word alignment, and sign/zero-extends load data. Stalls upstream stages while an access is outstanding, and produces the ALU_OUT_MEM and ALU_DATA_WB values consumed by the EX forwarding muxes.

## Interface
- TIMEOUT, 16: maximum cycles an access may stay outstanding before it is aborted (range 2–255).

- clk  in  1  pipeline clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- ALU_OUT_EX  in  32  ALU result / effective address
- REG_DATA2_EX_FINAL  in  32  forwarded store data
- RD_EX  in  5  destination register
- FUNCT3_EX  in  3  access size/sign
- RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX  in  1 each  control
- dmem_rdata  in  32  word read data, valid when dmem_ready=1
- dmem_ready  in  1  access complete
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  {addr[31:2],2'b00}
- dmem_wstrb  out  4  byte-lane enables (stores only, else 0)
- dmem_wdata  out  32  lane-replicated store data
- stall_MEM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misalign_MEM  out  1  one-cycle flag: misaligned or illegal funct3 access
- bus_err_MEM  out  1  one-cycle flag: access timed out
- ALU_OUT_MEM, RD_MEM, RegWrite_MEM  out  32/5/1  EX/MEM register contents
- ALU_DATA_WB, RD_WB, RegWrite_WB  out  32/5/1  MEM/WB register contents (final write-back value)

## Operation
- EX/MEM register loads all EX inputs on each edge where stall_MEM=0; holds when stall_MEM=1.
- mem_op = MemRead_MEM | MemWrite_MEM (store wins if both are set).
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Fault = half access with addr[0]=1, word access with addr[1:0]≠0, or any other funct3.
- A faulting op issues no request and does not stall. misalign_MEM=1 for that cycle, and MEM/WB receives RegWrite_WB=0.
- Byte lanes:
  - Byte: wstrb = 0001<<addr[1:0]; wdata = {4{byte}}.
  - Half: wstrb = addr[1] ? 1100 : 0011; wdata = {2{half}}.
  - Word: wstrb = 1111.
- Load data: select byte/half by addr[1:0]. Sign-extend for 000/001; zero-extend for 100/101.
- FSM states:
  - IDLE: dmem_req=0.
  - ACCESS: dmem_req=1; addr, we, wstrb and wdata stable from the EX/MEM register.
- Transitions:
  - IDLE→ACCESS on the edge that loads a legal mem_op into EX/MEM; wait counter cleared to 0.
  - ACCESS, dmem_ready=1: completes; stall_MEM=0. Next state is ACCESS if the incoming EX instruction is a legal mem_op, else IDLE.
  - ACCESS, dmem_ready=0, counter<TIMEOUT-1: stall_MEM=1; counter increments.
  - ACCESS, dmem_ready=0, counter=TIMEOUT-1: abort. stall_MEM=0, bus_err_MEM=1, MEM/WB gets RegWrite_WB=0, state advances as on completion.
- stall_MEM is combinational: (state==ACCESS) & ~dmem_ready & ~abort.
- MEM/WB loads on every edge where stall_MEM=0:
  - ALU_DATA_WB = MemtoReg ? extended load data : ALU_OUT_MEM.
  - RD_WB and RegWrite_WB copied, except RegWrite_WB=0 on fault or abort.
- While stall_MEM=1, MEM/WB is loaded with a bubble (RegWrite_WB=0, other fields unchanged).

## Timing
- Reset: every register and output is 0, state=IDLE, counter=0. Reset asserted mid-access drops dmem_req the following cycle with no completion.
- Zero-wait memory (dmem_ready in the first ACCESS cycle): 1 cycle in MEM, no stall; load data is visible on ALU_DATA_WB one edge later.
- N wait cycles stall the pipeline for exactly N cycles.
- Back-to-back memory ops issue requests in consecutive cycles with no idle gap.
- dmem_ready while in IDLE is ignored.

## Test plan
- SW 0xDEADBEEF to 0x100, then LW 0x100 with zero-wait memory: ALU_DATA_WB=0xDEADBEEF, stall_MEM never high, wstrb=1111.
- SB 0x80 at 0x103, then LB 0x103: wstrb=1000, wdata=0x80808080, ALU_DATA_WB=0xFFFFFF80. LBU 0x103: 0x00000080.
- LH at 0x102 with dmem_ready delayed 3 cycles: stall_MEM high exactly 3 cycles, req/addr held stable, one write-back, halfword sign-extended correctly.
- LW at 0x101 with RegWrite_EX=1: no dmem_req, one misalign_MEM pulse, RegWrite_WB=0, no stall.
- dmem_ready held 0 with TIMEOUT=4: stall_MEM high 3 cycles, bus_err_MEM pulse in cycle 4, RegWrite_WB=0, next instruction proceeds.
- Reset asserted during the 2nd wait cycle: the next cycle shows dmem_req=0, stall_MEM=0, all outputs 0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory request/ready port of the MEM stage.
// The stage is the master; the memory answers on the slave side.
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_wstrb, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_wstrb, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: EX/MEM and MEM/WB registers, aligned data-memory
// access with wait/timeout handling and load extension.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_OUT_EX,
  input  logic [31:0] REG_DATA2_EX_FINAL,
  input  logic [4:0]  RD_EX,
  input  logic [2:0]  FUNCT3_EX,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic        MemRead_EX,
  input  logic        MemWrite_EX,
  mem_access_stage_if.master bus,
  output logic        stall_MEM,
  output logic        misalign_MEM,
  output logic        bus_err_MEM,
  output logic [31:0] ALU_OUT_MEM,
  output logic [4:0]  RD_MEM,
  output logic        RegWrite_MEM,
  output logic [31:0] ALU_DATA_WB,
  output logic [4:0]  RD_WB,
  output logic        RegWrite_WB
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic [31:0] wsrc;
  logic [2:0]  f3;
  logic        m2r, mr, mw;
  logic [7:0]  wait_cnt;
  logic        req, abort;
  logic        mem_op, fault, ex_legal;
  logic [1:0]  a;
  logic [3:0]  lanes;
  logic [31:0] wd, ldata;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  // size/alignment legality; stores only allow 000/001/010
  function automatic logic legal(
    input logic       rd,
    input logic       wr,
    input logic [2:0] fn,
    input logic [1:0] ad
  );
    logic ok;
    case (fn)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~ad[0];
      3'b010:  ok = (ad == 2'b00);
      3'b100:  ok = ~wr;
      3'b101:  ok = ~wr & ~ad[0];
      default: ok = 1'b0;
    endcase
    return (rd | wr) & ok;
  endfunction

  assign a        = ALU_OUT_MEM[1:0];
  assign mem_op   = mr | mw;
  assign fault    = mem_op & ~legal(mr, mw, f3, a);
  assign ex_legal = legal(MemRead_EX, MemWrite_EX,
                          FUNCT3_EX, ALU_OUT_EX[1:0]);

  // EX/MEM register, frozen while the access is outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      ALU_OUT_MEM  <= '0;
      wsrc         <= '0;
      RD_MEM       <= '0;
      f3           <= '0;
      RegWrite_MEM <= 1'b0;
      m2r          <= 1'b0;
      mr           <= 1'b0;
      mw           <= 1'b0;
    end else if (!stall_MEM) begin
      ALU_OUT_MEM  <= ALU_OUT_EX;
      wsrc         <= REG_DATA2_EX_FINAL;
      RD_MEM       <= RD_EX;
      f3           <= FUNCT3_EX;
      RegWrite_MEM <= RegWrite_EX;
      m2r          <= MemtoReg_EX;
      mr           <= MemRead_EX;
      mw           <= MemWrite_EX;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state, request, stall and timeout abort
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    abort     = 1'b0;
    stall_MEM = 1'b0;
    case (state)
      IDLE: state_nxt = ex_legal ? ACCESS : IDLE;
      ACCESS: begin
        req       = 1'b1;
        abort     = ~bus.dmem_ready &
                    (wait_cnt == 8'(TIMEOUT - 1));
        stall_MEM = ~bus.dmem_ready & ~abort;
        if (!stall_MEM)
          state_nxt = ex_legal ? ACCESS : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // wait counter: restarts whenever the stage advances
  always_ff @(posedge clk) begin
    if (reset || !stall_MEM) wait_cnt <= '0;
    else                     wait_cnt <= wait_cnt + 8'd1;
  end

  // store lane enables and replicated write data
  always_comb begin
    lanes = 4'b1111;
    wd    = wsrc;
    case (f3[1:0])
      2'b00: begin
        lanes = 4'b0001 << a;
        wd    = {4{wsrc[7:0]}};
      end
      2'b01: begin
        lanes = a[1] ? 4'b1100 : 4'b0011;
        wd    = {2{wsrc[15:0]}};
      end
      default: ;
    endcase
  end

  // load lane select and sign/zero extension
  always_comb begin
    case (a)
      2'd0:    bsel = bus.dmem_rdata[7:0];
      2'd1:    bsel = bus.dmem_rdata[15:8];
      2'd2:    bsel = bus.dmem_rdata[23:16];
      default: bsel = bus.dmem_rdata[31:24];
    endcase
    hsel = a[1] ? bus.dmem_rdata[31:16]
                : bus.dmem_rdata[15:0];
    case (f3)
      3'b000:  ldata = {{24{bsel[7]}}, bsel};
      3'b001:  ldata = {{16{hsel[15]}}, hsel};
      3'b100:  ldata = {24'b0, bsel};
      3'b101:  ldata = {16'b0, hsel};
      default: ldata = bus.dmem_rdata;
    endcase
  end

  assign bus.dmem_req   = req;
  assign bus.dmem_we    = mw;
  assign bus.dmem_addr  = {ALU_OUT_MEM[31:2], 2'b00};
  assign bus.dmem_wstrb = (req & mw) ? lanes : 4'b0000;
  assign bus.dmem_wdata = wd;
  assign misalign_MEM   = fault;
  assign bus_err_MEM    = abort;

  // MEM/WB register; a stall inserts a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ALU_DATA_WB <= '0;
      RD_WB       <= '0;
      RegWrite_WB <= 1'b0;
    end else if (stall_MEM) begin
      RegWrite_WB <= 1'b0;
    end else begin
      ALU_DATA_WB <= m2r ? ldata : ALU_OUT_MEM;
      RD_WB       <= RD_MEM;
      RegWrite_WB <= RegWrite_MEM & ~fault & ~abort;
    end
  end

endmodule
